// File: rtl/drop_field.sv
// Purpose : rain-drop field generator; owns the gs x gs drop field and drives the
//           8x8 scanner's enable/done handshake, stepping the field every
//           FRAMES_PER_STEP completed scans with a new LFSR-spawned top row.
// Latency : Moore outputs from registered state; e_disp_o rises 2 cycles after
//           reset release, and the field updates 1 cycle after a terminal BLANK.
// Backpres: the scanner throttles via d_disp_i; SHOW holds until it reports done,
//           and there is no other stall source.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (dominates everything)
//   d_disp_i  scan-done from scanner, only looked at in SHOW
//   pause_i   freeze the field at step time (only with DROPS_PAUSE_EN)
//   matrix_o  field, bit gs*r+c = row r / col c, row 0 = top
//   e_disp_o  scanner enable, high only in SHOW
//   step_o    one-cycle pulse while the field advances
//
// Optional feature macro: DROPS_PAUSE_EN (adds pause_i).
module drop_field #(
    parameter int unsigned gs              = 8,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_disp_i,
`ifdef DROPS_PAUSE_EN
    input  logic              pause_i,
`endif
    output logic [gs*gs-1:0]  matrix_o,
    output logic              e_disp_o,
    output logic              step_o
);

    localparam int unsigned FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned CW   = $clog2(gs);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        BLANK  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [gs*gs-1:0]  matrix_q, matrix_d;
    logic [7:0]        lfsr_next;
    logic [gs-1:0]     row0_new;
    logic              pause_w;

`ifdef DROPS_PAUSE_EN
    assign pause_w = pause_i;
`else
    assign pause_w = 1'b0;
`endif

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // New top row is derived from the value being loaded, not the old LFSR state.
    always_comb begin
        row0_new = '0;
        if (lfsr_next[7]) begin
            row0_new[lfsr_next[CW-1:0]] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lfsr_d      = lfsr_q;
        matrix_d    = matrix_q;
        case (state_q)
            IDLE: begin
                state_d = SHOW;
            end
            SHOW: begin
                if (d_disp_i) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                // BLANK is always exactly one cycle so the scanner sees enable low.
                if (frame_cnt_q == FC_LAST) begin
                    if (pause_w) begin
                        // Counter stays terminal so the first unpaused BLANK steps.
                        state_d = SHOW;
                    end else begin
                        frame_cnt_d = '0;
                        state_d     = UPDATE;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = SHOW;
                end
            end
            UPDATE: begin
                lfsr_d   = lfsr_next;
                // Shift every row down one; the bottom row falls off.
                matrix_d = {matrix_q[gs*gs-gs-1:0], row0_new};
                state_d  = SHOW;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
            matrix_q    <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lfsr_q      <= lfsr_d;
            matrix_q    <= matrix_d;
        end
    end

    assign matrix_o = matrix_q;
    assign e_disp_o = (state_q == SHOW);
    assign step_o   = (state_q == UPDATE);

endmodule

// File: tb/tb_drop_field.sv
// Purpose : self-checking bench for drop_field with a behavioural 8x8 scanner.
// Latency : scanner raises done 20 cycles after enable rises, drops it with enable.
// Backpres: none beyond the modelled scanner handshake.
module tb_drop_field;

    logic        clk;
    logic        rst;
    logic        d_disp;
    logic [63:0] matrix;
    logic        e_disp;
    logic        step;
`ifdef DROPS_PAUSE_EN
    logic        pause;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    drop_field #(
        .gs              (8),
        .FRAMES_PER_STEP (4),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .d_disp_i (d_disp),
`ifdef DROPS_PAUSE_EN
        .pause_i  (pause),
`endif
        .matrix_o (matrix),
        .e_disp_o (e_disp),
        .step_o   (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scanner model: done goes high 20 cycles into an enabled frame, low with enable.
    initial begin
        int scan_cnt;
        scan_cnt = 0;
        d_disp   = 1'b0;
        forever begin
            @(negedge clk);
            if (e_disp === 1'b1) begin
                scan_cnt++;
                d_disp = (scan_cnt >= 20);
            end else begin
                scan_cnt = 0;
                d_disp   = 1'b0;
            end
        end
    end

    // Field must be stable and no step may occur while the scanner is enabled.
    initial begin
        logic        prev_e;
        logic [63:0] prev_m;
        prev_e = 1'b0;
        prev_m = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (e_disp === 1'b1 && step !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_step_during_show: step_o=%b while e_disp_o=1, required 0", step);
                end
                n_checks++;
                if (prev_e === 1'b1 && e_disp === 1'b1 && matrix !== prev_m) begin
                    n_fail++;
                    $display("FAIL mon_matrix_during_show: matrix_o=%h changed from %h while e_disp_o=1", matrix, prev_m);
                end
            end
            prev_e = e_disp;
            prev_m = matrix;
        end
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Advance to a negedge where enable is high.
    task automatic wait_show(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (e_disp === 1'b1) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_wait_show: e_disp_o never rose within 10 cycles, required 1", name);
        end
    endtask

    // Entered at a negedge with enable high; returns at the next negedge with enable
    // high, reporting the length of the low gap and the step cycles inside it.
    task automatic run_scan(output int low_len, output int step_cyc, output bit ok);
        ok       = 0;
        low_len  = 0;
        step_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (e_disp !== 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            low_len++;
            if (step === 1'b1) step_cyc++;
            @(negedge clk);
            if (e_disp === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (matrix !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_matrix: got %h, required 0", matrix);
            end
            n_checks++;
            if (e_disp !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_e_disp: got %b, required 0", e_disp);
            end
            n_checks++;
            if (step !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_step: got %b, required 0", step);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (e_disp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_cycle1: e_disp_o=%b, required 0", e_disp);
        end
        @(negedge clk);
        n_checks++;
        if (e_disp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_cycle2: e_disp_o=%b, required 1", e_disp);
        end
    endtask

    // Starts right after test_reset, so frame counter is at zero.
    task automatic test_frames();
        int low_len, step_cyc, total_steps;
        bit ok;
        total_steps = 0;
        for (int k = 1; k <= 12; k++) begin
            run_scan(low_len, step_cyc, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL frames_timeout: scan %0d did not complete, required completion", k);
                break;
            end
            total_steps += step_cyc;
            n_checks++;
            if (low_len != ((k % 4 == 0) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL frames_gap: scan %0d enable low %0d cycles, required %0d", k, low_len, (k % 4 == 0) ? 2 : 1);
            end
            n_checks++;
            if (step_cyc != ((k % 4 == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL frames_step_width: scan %0d step_o high %0d cycles, required %0d", k, step_cyc, (k % 4 == 0) ? 1 : 0);
            end
        end
        n_checks++;
        if (total_steps != 3) begin
            n_fail++;
            $display("FAIL frames_step_count: got %0d steps, required 3", total_steps);
        end
    endtask

    // Entered at a negedge in the first SHOW after reset.
    task automatic check_steps(input string name);
        logic [7:0]  m_lfsr;
        logic [63:0] m_mat;
        logic [7:0]  row0;
        int low_len, step_cyc, steps;
        bit ok;
        m_lfsr = 8'hA5;
        m_mat  = '0;
        steps  = 0;
        for (int s = 0; s < 120 && steps < 20; s++) begin
            run_scan(low_len, step_cyc, ok);
            if (!ok) break;
            if (step_cyc > 0) begin
                steps++;
                m_lfsr = lfsr_step(m_lfsr);
                row0   = '0;
                if (m_lfsr[7]) row0[m_lfsr[2:0]] = 1'b1;
                m_mat  = {m_mat[55:0], row0};
                n_checks++;
                if (matrix !== m_mat) begin
                    n_fail++;
                    $display("FAIL %s_step%0d: matrix_o=%h, required %h", name, steps, matrix, m_mat);
                end
                if (steps == 2) begin
                    n_checks++;
                    if (matrix !== 64'h0000_0000_0000_0020) begin
                        n_fail++;
                        $display("FAIL %s_hand_step2: matrix_o=%h, required 20", name, matrix);
                    end
                end
                if (steps == 5) begin
                    n_checks++;
                    if (matrix !== 64'h0000_0000_2000_0002) begin
                        n_fail++;
                        $display("FAIL %s_hand_step5: matrix_o=%h, required 2000_0002", name, matrix);
                    end
                end
                if (steps == 9) begin
                    n_checks++;
                    if (matrix[61] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s_drop_row7: bit61=%b, required 1", name, matrix[61]);
                    end
                end
                if (steps == 10) begin
                    n_checks++;
                    if (matrix[63:56] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL %s_drop_gone: row7=%h, required 00", name, matrix[63:56]);
                    end
                end
            end
        end
        n_checks++;
        if (steps != 20) begin
            n_fail++;
            $display("FAIL %s_step_total: got %0d steps, required 20", name, steps);
        end
    endtask

    task automatic test_steps();
        apply_reset();
        wait_show("steps");
        check_steps("steps");
    endtask

    task automatic test_reset_mid();
        int low_len, step_cyc, steps;
        bit ok;
        apply_reset();
        wait_show("rstmid");
        steps = 0;
        for (int s = 0; s < 40 && steps < 4; s++) begin
            run_scan(low_len, step_cyc, ok);
            if (!ok) break;
            steps += step_cyc;
        end
        n_checks++;
        if (steps != 4) begin
            n_fail++;
            $display("FAIL rstmid_prestep: got %0d steps, required 4", steps);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (matrix !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_matrix: got %h, required 0", matrix);
        end
        n_checks++;
        if (e_disp !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_e_disp: got %b, required 0", e_disp);
        end
        wait_show("rstmid");
        check_steps("rstmid");
    endtask

`ifdef DROPS_PAUSE_EN
    task automatic test_pause();
        int low_len, step_cyc, steps;
        bit ok;
        pause = 1'b0;
        apply_reset();
        wait_show("pause");
        steps = 0;
        for (int s = 0; s < 20 && steps < 2; s++) begin
            run_scan(low_len, step_cyc, ok);
            if (!ok) break;
            steps += step_cyc;
        end
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run_scan(low_len, step_cyc, ok);
            n_checks++;
            if (!ok || low_len != 1 || step_cyc != 0) begin
                n_fail++;
                $display("FAIL pause_scan%0d: ok=%0d gap=%0d steps=%0d, required ok=1 gap=1 steps=0", k, ok, low_len, step_cyc);
            end
            n_checks++;
            if (matrix !== 64'h20) begin
                n_fail++;
                $display("FAIL pause_frozen%0d: matrix_o=%h, required 20", k, matrix);
            end
        end
        pause = 1'b0;
        run_scan(low_len, step_cyc, ok);
        n_checks++;
        if (step_cyc != 1) begin
            n_fail++;
            $display("FAIL pause_resume_step: step_o high %0d cycles, required 1", step_cyc);
        end
        n_checks++;
        if (matrix !== 64'h2000) begin
            n_fail++;
            $display("FAIL pause_resume_matrix: matrix_o=%h, required 2000", matrix);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
`ifdef DROPS_PAUSE_EN
        pause = 1'b0;
`endif
        test_reset();
        mon_en = 1;
        test_frames();
        test_steps();
        test_reset_mid();
`ifdef DROPS_PAUSE_EN
        test_pause();
`endif
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
